// File: rtl/arm_ctrl_pkg.sv
// Shared control-path definitions: main FSM states, Op classes and ALU encodings.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// Data-processing command decode: ALU operation, flag-write groups and compare write suppression.
module alu_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [4:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic [3:0] cmd;
    logic       s_bit;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        if (alu_op) begin
            // C,V only meaningful for arithmetic ops; logic ops update N,Z alone
            case (cmd)
                CMD_ADD: begin
                    alu_control = ALU_ADD;
                    flag_w      = {s_bit, s_bit};
                end
                CMD_SUB: begin
                    alu_control = ALU_SUB;
                    flag_w      = {s_bit, s_bit};
                end
                CMD_AND: begin
                    alu_control = ALU_AND;
                    flag_w      = {s_bit, 1'b0};
                end
                CMD_ORR: begin
                    alu_control = ALU_ORR;
                    flag_w      = {s_bit, 1'b0};
                end
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    flag_w      = {s_bit, s_bit};
                    no_write    = 1'b1;
                end
                default: begin
                    alu_control = ALU_ADD;
                    flag_w      = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_main_decoder.sv
// Multicycle main controller: Moore FSM sequencing fetch/decode/execute with ALU decode sub-block.
//   state    | meaning
//   FETCH    | load IR, PC <= PC+4
//   DECODE   | read registers, dispatch on Op
//   MEMADR   | compute load/store address
//   MEMREAD  | read data memory
//   MEMWB    | write load data to register file
//   MEMWRITE | write store data to memory
//   EXECUTER | ALU op with register operand
//   EXECUTEI | ALU op with immediate operand
//   ALUWB    | write ALU result to register file
//   BRANCH   | write branch target to PC
module multicycle_main_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl
);

    state_t state, state_next;
    logic   alu_op;
    logic   branch;
    logic   no_write_alu;
    logic   cmp_hold;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = FETCH;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        RegW      = 1'b0;
        MemW      = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Compare must keep suppressing the write into ALUWB, where the ALU decode is idle
    assign cmp_hold = (state == ALUWB) && (Op == OP_DP) && (Funct[4:1] == CMD_CMP);
    assign NoWrite  = no_write_alu | cmp_hold;
    assign PCS      = (RegW && (Rd == 4'hF)) || branch;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct[4:0]),
        .alu_control (ALUControl),
        .flag_w      (FlagW),
        .no_write    (no_write_alu)
    );

endmodule

// File: tb/tb_multicycle_main_decoder.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, a negedge monitor pops and compares.
module tb_multicycle_main_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl;

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       nowrite;
        logic       irw;
        logic       npc;
        logic       adrsrc;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluc;
    } out_t;

    out_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    out_t v_fetch, v_decode, v_memadr, v_memread, v_memwb, v_memwrite, v_branch;

    always #5 clk = ~clk;

    multicycle_main_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW),
        .NoWrite    (NoWrite),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl)
    );

    function automatic out_t mk(input logic pcs, input logic regw, input logic memw,
                                input logic [1:0] flagw, input logic nowrite, input logic irw,
                                input logic npc, input logic adrsrc, input logic [1:0] res,
                                input logic srca, input logic [1:0] srcb, input logic [1:0] aluc);
        out_t o;
        o.pcs = pcs; o.regw = regw; o.memw = memw; o.flagw = flagw; o.nowrite = nowrite;
        o.irw = irw; o.npc = npc; o.adrsrc = adrsrc; o.res = res; o.srca = srca;
        o.srcb = srcb; o.aluc = aluc;
        return o;
    endfunction

    function automatic out_t v_exec(input logic imm, input logic [1:0] aluc,
                                    input logic [1:0] flagw, input logic nowrite);
        return mk(0, 0, 0, flagw, nowrite, 0, 0, 0, 2'b00, 0, imm ? 2'b01 : 2'b00, aluc);
    endfunction

    function automatic out_t v_aluwb(input logic pcs, input logic nowrite);
        return mk(pcs, 1, 0, 2'b00, nowrite, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
    endfunction

    task automatic push(input out_t v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        Op = op; Funct = funct; Rd = rd;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e;
            out_t  a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC, AdrSrc,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %b required %b (pcs regw memw flagw nw irw npc adr res srca srcb aluc)",
                         t, a, e);
            end
        end
    end

    initial begin
        v_fetch    = mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 2'b10, 1, 2'b10, 2'b00);
        v_decode   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        v_memadr   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        v_memread  = mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
        v_memwb    = mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00);
        v_memwrite = mk(0, 0, 1, 2'b00, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
        v_branch   = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);

        reset = 1'b1;
        issue(2'b00, 6'b000000, 4'h0);
        cycles(1);
        push(v_fetch, "reset_fetch");
        cycles(1);
        push(v_fetch, "reset_hold");
        cycles(1);
        reset = 1'b0;

        // ADD R1
        issue(2'b00, 6'b001000, 4'h1);
        push(v_fetch, "add_fetch"); push(v_decode, "add_decode");
        push(v_exec(0, 2'b00, 2'b00, 0), "add_execr"); push(v_aluwb(0, 0), "add_aluwb");
        cycles(4);

        // CMP immediate, S=1
        issue(2'b00, 6'b110101, 4'h3);
        push(v_fetch, "cmp_fetch"); push(v_decode, "cmp_decode");
        push(v_exec(1, 2'b01, 2'b11, 1), "cmp_exec"); push(v_aluwb(0, 1), "cmp_aluwb");
        cycles(4);

        // LDR
        issue(2'b01, 6'b011001, 4'h2);
        push(v_fetch, "ldr_fetch"); push(v_decode, "ldr_decode"); push(v_memadr, "ldr_memadr");
        push(v_memread, "ldr_memread"); push(v_memwb, "ldr_memwb");
        cycles(5);

        // STR
        issue(2'b01, 6'b011000, 4'h2);
        push(v_fetch, "str_fetch"); push(v_decode, "str_decode"); push(v_memadr, "str_memadr");
        push(v_memwrite, "str_memwrite");
        cycles(4);

        // B
        issue(2'b10, 6'b100000, 4'h0);
        push(v_fetch, "b_fetch"); push(v_decode, "b_decode"); push(v_branch, "b_branch");
        cycles(3);

        // ADD PC
        issue(2'b00, 6'b001000, 4'hF);
        push(v_fetch, "addpc_fetch"); push(v_decode, "addpc_decode");
        push(v_exec(0, 2'b00, 2'b00, 0), "addpc_execr"); push(v_aluwb(1, 0), "addpc_aluwb");
        cycles(4);

        // Undefined Op
        issue(2'b11, 6'b111111, 4'hF);
        push(v_fetch, "undef_fetch"); push(v_decode, "undef_decode");
        cycles(2);

        // SUBS reg
        issue(2'b00, 6'b000101, 4'h4);
        push(v_fetch, "subs_fetch"); push(v_decode, "subs_decode");
        push(v_exec(0, 2'b01, 2'b11, 0), "subs_execr"); push(v_aluwb(0, 0), "subs_aluwb");
        cycles(4);

        // ANDS imm
        issue(2'b00, 6'b100001, 4'h5);
        push(v_fetch, "ands_fetch"); push(v_decode, "ands_decode");
        push(v_exec(1, 2'b10, 2'b10, 0), "ands_execi"); push(v_aluwb(0, 0), "ands_aluwb");
        cycles(4);

        // ORR reg, no S
        issue(2'b00, 6'b011000, 4'h6);
        push(v_fetch, "orr_fetch"); push(v_decode, "orr_decode");
        push(v_exec(0, 2'b11, 2'b00, 0), "orr_execr"); push(v_aluwb(0, 0), "orr_aluwb");
        cycles(4);

        // Unsupported cmd 0001 with S=1
        issue(2'b00, 6'b000011, 4'h7);
        push(v_fetch, "unk_fetch"); push(v_decode, "unk_decode");
        push(v_exec(0, 2'b00, 2'b00, 0), "unk_execr"); push(v_aluwb(0, 0), "unk_aluwb");
        cycles(4);

        // STR with reset raised in MEMWRITE
        issue(2'b01, 6'b011000, 4'h1);
        push(v_fetch, "strrst_fetch"); push(v_decode, "strrst_decode");
        push(v_memadr, "strrst_memadr"); push(v_memwrite, "strrst_memwrite");
        cycles(3);
        reset = 1'b1;
        cycles(1);
        push(v_fetch, "strrst_after");
        cycles(1);
        reset = 1'b0;

        // ADD PC with reset raised in ALUWB
        issue(2'b00, 6'b001000, 4'hF);
        push(v_fetch, "wbrst_fetch"); push(v_decode, "wbrst_decode");
        push(v_exec(0, 2'b00, 2'b00, 0), "wbrst_execr"); push(v_aluwb(1, 0), "wbrst_aluwb");
        cycles(3);
        reset = 1'b1;
        cycles(1);
        push(v_fetch, "wbrst_after");
        cycles(1);
        reset = 1'b0;

        // Back to normal after reset
        issue(2'b10, 6'b000000, 4'h0);
        push(v_fetch, "post_fetch"); push(v_decode, "post_decode"); push(v_branch, "post_branch");
        cycles(3);

        begin
            int waitc = 0;
            while (exp_q.size() > 0 && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            #1;
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
